// File: rtl/rtc_frame_loader_if.sv
// Bus bundle between the RTC capture sequencer, the RTC byte source and the
// character generator that reads the committed display bank.
interface rtc_frame_loader_if #(
  parameter int DW = 8,
  parameter int AW = 3
) ();
  logic          frame_tick;
  logic          upd_req;
  logic [DW-1:0] dato_rtc;
  logic          inicio_secuencia;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          commit;
  logic          overrun;

  modport master (
    output frame_tick, upd_req, dato_rtc, rd_addr,
    input  inicio_secuencia, rd_data, busy, commit, overrun
  );

  modport slave (
    input  frame_tick, upd_req, dato_rtc, rd_addr,
    output inicio_secuencia, rd_data, busy, commit, overrun
  );
endinterface

// File: rtl/rtc_frame_loader.sv
// Frame-synchronous RTC capture: bytes land in a shadow bank during the
// sequence and are copied to the display bank in one cycle, so reads never tear.
module rtc_frame_loader #(
  parameter int NUM_BYTES = 8,
  parameter int DW        = 8,
  parameter int AW        = 3
) (
  input  logic              clk,
  input  logic              reset,
  rtc_frame_loader_if.slave bus
);
  localparam int            CW   = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_FRAME = 3'd1,
    START      = 3'd2,
    CAPTURE    = 3'd3,
    COMMIT     = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic          pending_q, pending_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          overrun_q, overrun_d;
  logic [DW-1:0] shadow_q  [NUM_BYTES];
  logic [DW-1:0] display_q [NUM_BYTES];

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.upd_req) begin
          state_d = bus.frame_tick ? START : WAIT_FRAME;
        end
      end
      WAIT_FRAME: begin
        if (bus.frame_tick) begin
          state_d = START;
        end
      end
      START: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        if (cnt_q == LAST) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        // A request arriving in this very cycle must still queue a follow-up.
        state_d = (pending_q || bus.upd_req) ? WAIT_FRAME : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request bookkeeping and byte counter
  always_comb begin
    pending_d = pending_q;
    overrun_d = bus.upd_req && pending_q && (state_q != IDLE);
    if (state_d == START) begin
      pending_d = 1'b0;
    end else if (bus.upd_req) begin
      pending_d = 1'b1;
    end

    cnt_d = cnt_q;
    case (state_q)
      START:   cnt_d = '0;
      CAPTURE: if (cnt_q != LAST) cnt_d = cnt_q + 1'b1;
      COMMIT:  cnt_d = '0;
      default: cnt_d = cnt_q;
    endcase
  end

  // Shadow and display banks; reset wipes both so no partial data survives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        shadow_q[i]  <= '0;
        display_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (state_q == CAPTURE && cnt_q == CW'(i)) begin
          shadow_q[i] <= bus.dato_rtc;
        end
        if (state_q == COMMIT) begin
          display_q[i] <= shadow_q[i];
        end
      end
    end
  end

  // Output logic
  always_comb begin
    bus.inicio_secuencia = (state_q == START) || (state_q == CAPTURE);
    bus.busy             = (state_q != IDLE);
    bus.commit           = (state_q == COMMIT);
    bus.overrun          = overrun_q;
  end

  always_comb begin
    bus.rd_data = '0;
    if (int'(bus.rd_addr) < NUM_BYTES) begin
      bus.rd_data = display_q[bus.rd_addr];
    end
  end
endmodule

// File: doc/rtc_frame_loader.md
# rtc_frame_loader

Frame-synchronous capture sequencer between the RTC byte stream and the VGA display interface. On an update request it waits for the next frame tick, drives `inicio_secuencia`, captures NUM_BYTES consecutive `dato_rtc` bytes into a shadow bank, then commits them atomically to the display bank read by the character generator. The on-screen time/timer fields are therefore never torn mid-frame.

## Interface
- NUM_BYTES, 8, bytes per capture sequence (index 0 first on the bus)
- DW, 8, data width of each RTC byte
- AW, 3, display read address width (2^AW >= NUM_BYTES)

- clk  in  1  system clock (100 MHz); all state on rising edge
- reset  in  1  asynchronous, active-low (0 = reset); clears all state
- frame_tick  in  1  one-cycle pulse at start of vertical blanking
- upd_req  in  1  one-cycle pulse: new RTC data set is available
- dato_rtc  in  DW  RTC byte stream, one byte per cycle during capture
- inicio_secuencia  out  1  high while the sequence runs; RTC source streams bytes
- rd_addr  in  AW  display bank read address
- rd_data  out  DW  committed byte at rd_addr (combinational read)
- busy  out  1  high whenever state != IDLE
- commit  out  1  one-cycle pulse when the display bank updates
- overrun  out  1  one-cycle pulse when a request is dropped

## Operation
- States: IDLE, WAIT_FRAME, START, CAPTURE, COMMIT.
- `pending` flag: set by upd_req, cleared on entry to START. One-deep.
- IDLE: upd_req and frame_tick in the same cycle -> START. upd_req alone -> WAIT_FRAME, pending=1.
- WAIT_FRAME: frame_tick -> START. Other inputs are held; a further upd_req does not change the state.
- START: one cycle. inicio_secuencia=1. Byte counter=0. -> CAPTURE.
- CAPTURE: inicio_secuencia=1. Each cycle: shadow[cnt] <= dato_rtc, cnt++. When cnt reaches NUM_BYTES-1 (last byte written), -> COMMIT.
- COMMIT: one cycle. display[i] <= shadow[i] for all i. commit=1. inicio_secuencia=0. -> WAIT_FRAME if pending, else IDLE.
- upd_req during START, CAPTURE or COMMIT: sets pending. Next sequence starts on the next frame_tick after COMMIT.
- upd_req while pending=1 and the state is not IDLE: request is dropped and overrun=1 for that cycle. This includes WAIT_FRAME.
- frame_tick outside IDLE/WAIT_FRAME: ignored.
- rd_data = display[rd_addr] when rd_addr < NUM_BYTES, else 0. It never reads the shadow bank.
- Counter width: clog2(NUM_BYTES) bits. No wrap past NUM_BYTES-1.

## Timing
- Reset values: state=IDLE, pending=0, counter=0, shadow and display banks all 0. Outputs: inicio_secuencia=0, busy=0, commit=0, overrun=0, rd_data=0.
- Reset assertion mid-sequence aborts immediately. The display bank is cleared, with no partial commit.
- frame_tick at edge t (from IDLE+req or WAIT_FRAME):
  - START is active in cycle t+1.
  - byte k is sampled at the edge ending cycle t+2+k.
  - COMMIT is active in cycle t+2+NUM_BYTES.
  - the new rd_data is visible from cycle t+3+NUM_BYTES.
- inicio_secuencia is high for exactly NUM_BYTES+1 cycles (START + CAPTURE). The RTC source places byte 0 on the cycle after inicio_secuencia rises.
- commit, overrun: single-cycle registered pulses.
- Minimum request-to-display latency: NUM_BYTES+3 cycles. Maximum: one frame period plus NUM_BYTES+3.

## Test plan
- Reset, then read every address -> rd_data=0, busy=0, inicio_secuencia=0.
- upd_req, then frame_tick after 20 cycles; stream 24,4,3,23,12,21,5,6 -> inicio_secuencia high 9 cycles, commit pulses once, rd_addr 0..7 returns 24,4,3,23,12,21,5,6.
- Repeat with stream 1..8, but probe rd_data during CAPTURE -> old values 24..6 until the cycle after commit, then 1..8.
- upd_req during CAPTURE -> after COMMIT, state WAIT_FRAME; the next frame_tick starts a second sequence. A further upd_req while waiting -> overrun pulses once, and only one extra sequence runs.
- Drop reset to 0 during the 5th captured byte -> all outputs 0 immediately, display bank all 0, no commit pulse. After release, a new request+tick completes normally.
- upd_req and frame_tick coincident in IDLE -> START on the next cycle, with no extra frame wait.
